// File: rtl/pc_if.sv
// Fetch-control bundle between the pipeline front end and the program counter.
// The master drives the redirect/flow controls; the slave returns the fetch address and RAS status.
interface pc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             halt;
  logic             resume;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jump;
  logic             call;
  logic [WIDTH-1:0] jump_target;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_next;
  logic             valid;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, halt, resume, br_taken, br_target, jump, call, jump_target, ret,
    input  pc_out, pc_next, valid, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, halt, resume, br_taken, br_target, jump, call, jump_target, ret,
    output pc_out, pc_next, valid, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-address select, circular return-address stack and run/halt control.
//   state    | meaning
//   S_RESET  | first cycle after reset; pc_out holds RESET_VECTOR, valid=0
//   S_RUN    | fetching; pc_out advances every unstalled edge
//   S_HALTED | frozen until resume; valid=0
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      STEP         = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic clk,
  input logic rst_n,
  pc_if.slave bus
);

  localparam int unsigned      PW      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CW      = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    top_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             advance;
  logic             ras_has_data;
  logic             do_push;
  logic             do_pop;
  logic             ret_empty;

  assign pc_seq       = pc + STEP_W;
  assign top_ptr      = wr_ptr - PW'(1);
  assign ras_has_data = (count != '0);
  assign advance      = (state == S_RUN) && !bus.stall;
  // ret outranks call, so a simultaneous call never pushes
  assign do_pop       = advance && bus.ret && ras_has_data;
  assign ret_empty    = advance && bus.ret && !ras_has_data;
  assign do_push      = advance && !bus.ret && bus.call;

  always_comb begin
    pc_nxt = pc;
    if (advance) begin
      if (bus.ret) begin
        pc_nxt = ras_has_data ? ras[top_ptr] : pc_seq;
      end else if (bus.call || bus.jump) begin
        pc_nxt = bus.jump_target;
      end else if (bus.br_taken) begin
        pc_nxt = bus.br_target;
      end else begin
        pc_nxt = pc_seq;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_RUN;
      S_RUN:    if (!bus.stall && bus.halt) state_nxt = S_HALTED;
      S_HALTED: if (bus.resume) state_nxt = S_RUN;
      default:  state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else if (advance) begin
      pc <= pc_nxt;
    end
  end

  // Pushing while full lands on the oldest slot, since wr_ptr has wrapped onto it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= ret_empty;
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (count == DEPTH_C) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end else if (do_pop) begin
        wr_ptr <= top_ptr;
        count  <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      ras[wr_ptr] <= pc_seq;
    end
  end

  assign bus.pc_out        = pc;
  assign bus.pc_next       = pc_nxt;
  assign bus.valid         = (state == S_RUN);
  assign bus.ras_empty     = !ras_has_data;
  assign bus.ras_full      = (count == DEPTH_C);
  assign bus.ras_overflow  = overflow;
  assign bus.ras_underflow = underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Directed test of pc_unit against a queue-based reference model, with an 8-bit instance for wrap.
module tb_pc_unit;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pc_if #(.WIDTH(32)) bus ();
  pc_if #(.WIDTH(8))  bus8 ();

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h100), .STEP(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  pc_unit #(.WIDTH(8), .RESET_VECTOR(8'hF8), .STEP(4), .RAS_DEPTH(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: 0 reset, 1 run, 2 halted; RAS as a queue, newest at the back
  int          m_state = 0;
  logic [31:0] m_pc    = 32'h100;
  logic [31:0] m_ras[$];
  bit          m_ovf   = 0;
  bit          m_unf   = 0;
  bit          started = 0;

  function automatic logic [31:0] model_next();
    if (m_state == 1 && !bus.stall) begin
      if (bus.ret) return (m_ras.size() > 0) ? m_ras[$] : m_pc + 32'd4;
      if (bus.call || bus.jump) return bus.jump_target;
      if (bus.br_taken) return bus.br_target;
      return m_pc + 32'd4;
    end
    return m_pc;
  endfunction

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (!rst_n) begin
      m_state = 0;
      m_pc    = 32'h100;
      m_ras.delete();
      m_ovf   = 0;
      m_unf   = 0;
      started = 1;
    end else begin
      nxt   = model_next();
      m_unf = 0;
      if (m_state == 1) begin
        if (!bus.stall) begin
          if (bus.ret) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_unf = 1;
          end else if (bus.call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) begin
              void'(m_ras.pop_front());
              m_ovf = 1;
            end
          end
          m_pc = nxt;
          if (bus.halt) m_state = 2;
        end
      end else if (m_state == 2) begin
        if (bus.resume) m_state = 1;
      end else begin
        m_state = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("pc_out",        bus.pc_out,        m_pc);
      chk("pc_next",       bus.pc_next,       model_next());
      chk("valid",         32'(bus.valid),         32'(m_state == 1));
      chk("ras_empty",     32'(bus.ras_empty),     32'(m_ras.size() == 0));
      chk("ras_full",      32'(bus.ras_full),      32'(m_ras.size() == 4));
      chk("ras_overflow",  32'(bus.ras_overflow),  32'(m_ovf));
      chk("ras_underflow", 32'(bus.ras_underflow), 32'(m_unf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall = 0; bus.halt = 0; bus.resume = 0; bus.br_taken = 0; bus.br_target = '0;
    bus.jump = 0; bus.call = 0; bus.jump_target = '0; bus.ret = 0;
  endtask

  initial begin
    logic [31:0] ret_exp [4];
    ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24};
    bus8.stall = 0; bus8.halt = 0; bus8.resume = 0; bus8.br_taken = 0; bus8.br_target = '0;
    bus8.jump = 0; bus8.call = 0; bus8.jump_target = '0; bus8.ret = 0;
    clr();
    rst_n = 0;
    tick(); tick();
    chk("rst_pc", bus.pc_out, 32'h100);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_pc8", 32'(bus8.pc_out), 32'hF8);

    rst_n = 1;
    tick();
    chk("run0_pc", bus.pc_out, 32'h100);
    chk("run0_valid", 32'(bus.valid), 32'h1);
    chk("run0_pc8", 32'(bus8.pc_out), 32'hF8);
    tick();
    chk("run1_pc", bus.pc_out, 32'h104);
    chk("wrap_fc", 32'(bus8.pc_out), 32'hFC);
    tick();
    chk("run2_pc", bus.pc_out, 32'h108);
    chk("wrap_00", 32'(bus8.pc_out), 32'h00);

    // priority: ret over call over branch
    clr(); bus.jump = 1; bus.jump_target = 32'h4FC; tick();
    clr(); bus.call = 1; bus.jump_target = 32'h200; tick();
    chk("call_pc", bus.pc_out, 32'h200);
    clr(); bus.ret = 1; bus.call = 1; bus.jump_target = 32'h300;
    bus.br_taken = 1; bus.br_target = 32'h400; tick();
    chk("prio_ret_pc", bus.pc_out, 32'h500);
    chk("prio_ret_nopush", 32'(bus.ras_empty), 32'h1);
    clr(); bus.jump = 1; bus.jump_target = 32'h200; tick();
    clr(); bus.call = 1; bus.jump_target = 32'h300; bus.br_taken = 1; bus.br_target = 32'h400; tick();
    chk("prio_call_pc", bus.pc_out, 32'h300);
    clr(); bus.ret = 1; tick();
    chk("prio_ras_top", bus.pc_out, 32'h204);

    // nested calls past depth, then unwind into underflow
    clr(); bus.jump = 1; bus.jump_target = 32'h10; tick();
    for (int i = 1; i <= 5; i++) begin
      clr(); bus.call = 1; bus.jump_target = 32'(i + 1) * 32'h10; tick();
    end
    chk("ovf_pc", bus.pc_out, 32'h60);
    chk("ovf_full", 32'(bus.ras_full), 32'h1);
    chk("ovf_flag", 32'(bus.ras_overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      clr(); bus.ret = 1; tick();
      chk("unwind_pc", bus.pc_out, ret_exp[i]);
    end
    clr(); bus.ret = 1; tick();
    chk("unf_pc", bus.pc_out, 32'h28);
    chk("unf_pulse", 32'(bus.ras_underflow), 32'h1);
    clr(); tick();
    chk("unf_clear", 32'(bus.ras_underflow), 32'h0);
    chk("unf_next_pc", bus.pc_out, 32'h2C);

    // stall holds PC and RAS
    clr(); bus.jump = 1; bus.jump_target = 32'h80; tick();
    clr(); bus.stall = 1; bus.call = 1; bus.jump_target = 32'h900;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.pc_out, 32'h80);
      chk("stall_ras", 32'(bus.ras_empty), 32'h1);
    end
    bus.stall = 0; tick();
    chk("unstall_pc", bus.pc_out, 32'h900);
    clr(); bus.ret = 1; tick();
    chk("stall_push_val", bus.pc_out, 32'h84);
    chk("stall_push_once", 32'(bus.ras_empty), 32'h1);

    // halt / resume
    clr(); bus.jump = 1; bus.jump_target = 32'h40; tick();
    clr(); bus.halt = 1; tick();
    chk("halt_pc", bus.pc_out, 32'h44);
    chk("halt_valid", 32'(bus.valid), 32'h0);
    clr(); bus.call = 1; bus.jump_target = 32'h700;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halted_pc", bus.pc_out, 32'h44);
      chk("halted_valid", 32'(bus.valid), 32'h0);
    end
    clr(); bus.halt = 1; bus.resume = 1; tick();
    chk("resume_pc", bus.pc_out, 32'h44);
    chk("resume_valid", 32'(bus.valid), 32'h1);
    clr(); tick();
    chk("resume_next", bus.pc_out, 32'h48);

    // reset mid-operation beats a pending ret
    clr(); bus.call = 1; bus.jump_target = 32'h600; tick();
    clr(); bus.ret = 1; rst_n = 0; tick();
    chk("mid_rst_pc", bus.pc_out, 32'h100);
    chk("mid_rst_empty", 32'(bus.ras_empty), 32'h1);
    chk("mid_rst_ovf", 32'(bus.ras_overflow), 32'h0);
    chk("mid_rst_pc8", 32'(bus8.pc_out), 32'hF8);
    clr(); rst_n = 1; tick(); tick();
    chk("post_rst_pc", bus.pc_out, 32'h104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter for the single-cycle/pipelined datapath. It holds the fetch address and selects the next address from sequential increment, branch, jump/call or return. An internal return-address stack (RAS) supports call/return. A small control FSM handles the reset, run and halt states.

Parameters:
WIDTH, 32, address width in bits.
RESET_VECTOR, 0, value loaded into pc_out on reset (WIDTH bits).
STEP, 4, sequential increment in bytes.
RAS_DEPTH, 4, return-address stack entries (power of two, at least 2).

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
stall  in  1  hold pc_out and the RAS this cycle.
halt  in  1  request entry to HALTED.
resume  in  1  request exit from HALTED.
br_taken  in  1  conditional branch resolved taken.
br_target  in  WIDTH  branch destination.
jump  in  1  unconditional jump to jump_target.
call  in  1  jump to jump_target and push pc_out+STEP.
jump_target  in  WIDTH  jump/call destination.
ret  in  1  pop the RAS and redirect to the popped address.
pc_out  out  WIDTH  current fetch address (registered).
pc_next  out  WIDTH  address to be loaded at the next edge (combinational).
valid  out  1  pc_out is a real fetch address (state RUN).
ras_empty  out  1  RAS count is 0.
ras_full  out  1  RAS count equals RAS_DEPTH.
ras_overflow  out  1  sticky flag: a push occurred while full.
ras_underflow  out  1  one-cycle pulse: ret occurred while empty.

Behaviour:
- Reset (rst_n=0 at posedge): pc_out=RESET_VECTOR, state=RESET, RAS count=0, top pointer=0, ras_overflow=0, ras_underflow=0, valid=0. All other inputs are ignored.
- FSM:
  - RESET: goes to RUN on the first edge with rst_n=1. pc_out is not advanced on that edge; valid rises with RUN.
  - RUN: pc_out<=pc_next each edge unless stall=1. halt=1 (with stall=0) moves to HALTED; pc_out still loads pc_next on that edge.
  - HALTED: pc_out and the RAS are frozen; valid=0; pc_next=pc_out. resume=1 moves to RUN on the next edge, and pc_out is unchanged on that edge. halt and resume together in HALTED: resume wins.
- pc_next selection in RUN with stall=0, highest priority first:
  - ret: popped RAS top (pc_out+STEP if the RAS is empty).
  - call or jump: jump_target.
  - br_taken: br_target.
  - otherwise: pc_out+STEP.
- In RUN with stall=1, or in any other state: pc_next=pc_out.
- Arithmetic: all additions are modulo 2^WIDTH. pc_out=2^WIDTH-STEP with sequential flow wraps to 0. No alignment masking is applied to targets.
- RAS is a circular buffer. Push and pop act only when the edge actually advances the PC (state RUN, stall=0).
  - call: push pc_out+STEP; count saturates at RAS_DEPTH.
  - Push while full: overwrites the oldest entry and sets ras_overflow (cleared only by reset).
  - ret with count>0: pop; count decrements.
  - ret with count=0: no pop, PC falls back to pc_out+STEP, ras_underflow pulses high for the following cycle.
  - ret and call together: ret wins; no push occurs.
- Stall or HALTED suppresses push, pop and the underflow pulse.
- Reset mid-operation overrides everything on that edge, including a pending call or ret.
- Latency: a redirect presented in cycle N appears on pc_out after edge N. pc_next reflects the inputs combinationally within the same cycle.

Test Plan:
- Reset then free-run, RESET_VECTOR=0x100, STEP=4: pc_out=0x100 in RESET and the first RUN cycle, then 0x104, 0x108. valid=0 during reset, 1 thereafter.
- Priority: from pc_out=0x200, set ret (RAS top=0x500), call (jump_target=0x300) and br_taken (br_target=0x400) together -> next pc_out=0x500, no push. Repeat without ret -> 0x300 and RAS top=0x204.
- RAS_DEPTH=4: five nested calls from 0x10,0x20,0x30,0x40,0x50 -> ras_full=1, ras_overflow=1. Five rets return 0x54,0x44,0x34,0x24, then underflow pulse with fallback to pc_out+4.
- Stall: assert stall for 3 cycles with call=1 at pc_out=0x80 -> pc_out holds 0x80 and the RAS is unchanged. Release -> pc_out=jump_target and the push of 0x84 occurs once.
- Halt/resume: halt at pc_out=0x40 -> pc_out=0x44, then frozen with valid=0 for 5 cycles. resume -> RUN with pc_out=0x44, then 0x48.
- Wrap and reset: WIDTH=8, pc_out=0xFC -> next 0x00. Assert rst_n=0 while ret=1 -> pc_out=RESET_VECTOR, ras_empty=1, ras_overflow=0.
